// File: rtl/extractor_dispatcher_if.sv
// Packet stream bundle between the source, the dispatcher
// and the shared extractor broadcast bus.
interface extractor_dispatcher_if #(
   parameter int numExtraction = 8,
   parameter int widthPkt      = 134,
   parameter int widthPktID    = 8
);
   logic                     in_valid;
   logic                     in_sop;
   logic                     in_eop;
   logic [widthPkt-1:0]      in_data;
   logic                     in_ready;
   logic [numExtraction-1:0] out_valid;
   logic                     out_sop;
   logic                     out_eop;
   logic [widthPkt-1:0]      out_data;
   logic [widthPktID-1:0]    out_pktID;

   modport master (
      output in_valid, in_sop, in_eop, in_data,
      input  in_ready,
      input  out_valid, out_sop, out_eop,
      input  out_data, out_pktID
   );

   modport slave (
      input  in_valid, in_sop, in_eop, in_data,
      output in_ready,
      output out_valid, out_sop, out_eop,
      output out_data, out_pktID
   );
endinterface

// File: rtl/extractor_dispatcher.sv
// Round-robin packet dispatcher for the header extractors;
// stamps each packet with a pktID and tracks extractor busy state.
module extractor_dispatcher #(
   parameter int numExtraction = 8,
   parameter int widthPkt      = 134,
   parameter int widthPktID    = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   extractor_dispatcher_if.slave    bus,
   input  logic [numExtraction-1:0] done,
   output logic [numExtraction-1:0] busy_vec,
   output logic [31:0]              pkt_cnt,
   output logic [15:0]              drop_cnt
);
   localparam int PW = $clog2(numExtraction);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1
   } state_t;

   state_t                  state, state_d;
   logic [PW-1:0]           rr_ptr, cur, sel, tgt;
   logic [widthPktID-1:0]   pkt_id;
   logic [numExtraction-1:0] free, busy_d;
   logic                    any_free, xfer;
   logic                    fwd, start, drop, pid_inc, sop_o;

   assign free     = ~busy_vec | done;
   assign any_free = |free;
   assign bus.in_ready = (state == FWD) | ((state == IDLE) & any_free);
   assign xfer     = bus.in_valid & bus.in_ready;

   // first free extractor at or after rr_ptr, wrapping
   always_comb begin
      logic       hit;
      logic [PW-1:0] idx;
      sel = '0;
      hit = 1'b0;
      idx = '0;
      for (int k = 0; k < numExtraction; k++) begin
         idx = rr_ptr + PW'(k);
         if (!hit && free[idx]) begin
            sel = idx;
            hit = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state;
      fwd     = 1'b0;
      start   = 1'b0;
      drop    = 1'b0;
      pid_inc = 1'b0;
      sop_o   = bus.in_sop;
      tgt     = cur;
      case (state)
         IDLE: begin
            if (xfer) begin
               if (bus.in_sop) begin
                  start = 1'b1;
                  fwd   = 1'b1;
                  tgt   = sel;
                  if (bus.in_eop) pid_inc = 1'b1;
                  else            state_d = FWD;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         FWD: begin
            if (xfer) begin
               fwd = 1'b1;
               if (bus.in_sop) begin
                  drop  = 1'b1;
                  sop_o = 1'b0;
               end
               if (bus.in_eop) begin
                  pid_inc = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // a new claim beats a same-cycle release of that extractor
   always_comb begin
      busy_d = busy_vec & ~done;
      if (start) busy_d[sel] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_valid <= '0;
         bus.out_sop   <= 1'b0;
         bus.out_eop   <= 1'b0;
         bus.out_data  <= '0;
         bus.out_pktID <= '0;
         busy_vec      <= '0;
         pkt_cnt       <= '0;
         drop_cnt      <= '0;
         rr_ptr        <= '0;
         cur           <= '0;
         pkt_id        <= '0;
      end else begin
         busy_vec      <= busy_d;
         bus.out_valid <= fwd ? (numExtraction'(1) << tgt) : '0;
         if (fwd) begin
            bus.out_data  <= bus.in_data;
            bus.out_sop   <= sop_o;
            bus.out_eop   <= bus.in_eop;
            bus.out_pktID <= pkt_id;
         end
         if (start) begin
            rr_ptr  <= sel + PW'(1);
            cur     <= sel;
            pkt_cnt <= pkt_cnt + 32'd1;
         end
         if (pid_inc) pkt_id <= pkt_id + widthPktID'(1);
         if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end
endmodule
